delay_ctrl: RTL and testbench
=============================

DELAY_CTRL -- requirements
Module: delay_ctrl

Interface
REQ-001 The module SHALL have parameter A_WIDTH, default 9, RAM address width and offset width.
REQ-002 The module SHALL have parameter D_WIDTH, default 8, data width and incr width.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: asynchronous reset, active-high.
REQ-005 Port start, input, 1: begin a delay session; sampled in IDLE only.
REQ-006 Port stop, input, 1: abort the session, return to IDLE.
REQ-007 Port offset_in, input, A_WIDTH: requested delay in samples; latched on accepted start.
REQ-008 Port sample_tick, input, 1: one-cycle strobe per audio sample.
REQ-009 Port ctr_rst, output, 1: clears the external address counter.
REQ-010 Port en, output, 1: address counter enable.
REQ-011 Port incr, output, D_WIDTH: counter increment; constant 1.
REQ-012 Port wr, output, 1: RAM write enable.
REQ-013 Port rd, output, 1: RAM read enable.
REQ-014 Port offset, output, A_WIDTH: latched delay, write-address offset.
REQ-015 Port dout_valid, output, 1: RAM dout holds a valid delayed sample.
REQ-016 Port busy, output, 1: high in any state other than IDLE.
REQ-017 Port state, output, 2: IDLE=0, LOAD=1, FILL=2, RUN=3.

Function
REQ-018 The FSM SHALL go IDLE->LOAD on start; start in any other state SHALL be ignored.
REQ-019 On an accepted start, offset SHALL latch offset_in, and fill_cnt (A_WIDTH) SHALL load offset_in.
REQ-020 LOAD SHALL last exactly one cycle with ctr_rst=1, and en/wr/rd=0 regardless of sample_tick.
REQ-021 LOAD SHALL go to FILL if fill_cnt!=0, and directly to RUN if fill_cnt==0.
REQ-022 In FILL, each sample_tick SHALL give en=1, wr=1, rd=0 that cycle and decrement fill_cnt.
REQ-023 A FILL tick that takes fill_cnt from 1 to 0 SHALL move the FSM to RUN on the next edge.
REQ-024 In RUN, each sample_tick SHALL give en=1, wr=1, rd=1 that cycle.
REQ-025 en, wr, rd and ctr_rst SHALL be combinational from state, sample_tick and stop; no tick means all 0.
REQ-026 dout_valid SHALL be registered, high exactly one cycle after each rd=1 cycle, otherwise 0.
REQ-027 incr SHALL be constant 1 (zero-extended to D_WIDTH).
REQ-028 offset SHALL hold its value until the next accepted start; the FSM SHALL return to IDLE only on stop (or rst).
REQ-029 stop in LOAD, FILL or RUN SHALL force IDLE on the next edge, and suppress en/wr/rd in that same cycle even if sample_tick=1.
REQ-030 stop and start together in IDLE: start SHALL win (stop is a no-op in IDLE).
REQ-031 fill_cnt SHALL never wrap; ticks in RUN SHALL not touch it.
REQ-032 Maximum delay SHALL be 2**A_WIDTH-1 samples; the address wrap-around is owned by the external counter.

Reset
REQ-033 While rst=1, the block SHALL be in state IDLE with offset=0, fill_cnt=0, dout_valid=0 and busy=0.
REQ-034 While rst=1, en, wr, rd and ctr_rst SHALL be 0, and incr SHALL be 1.
REQ-035 rst asserted mid-session SHALL abort at once, with no further wr/rd until a new start.

Verification
REQ-036 Scenario: start with offset_in=3, then ticks every 4 cycles -> LOAD 1 cycle with ctr_rst=1; first 3 ticks wr=1/rd=0; 4th tick rd=1; dout_valid high the cycle after.
REQ-037 Scenario: offset_in=0 -> LOAD then RUN; the first tick gives wr=1, rd=1.
REQ-038 Scenario: stop in the same cycle as a RUN tick -> en/wr/rd=0 that cycle; IDLE next cycle; offset retained.
REQ-039 Scenario: start pulses during FILL and RUN -> no effect on state, offset or fill_cnt.
REQ-040 Scenario: rst asserted in FILL with fill_cnt=2 -> immediate IDLE with all outputs at reset values; a new start with offset_in=5 re-fills 5 ticks.
REQ-041 Scenario: back-to-back ticks every cycle in RUN -> rd=1 each cycle, dout_valid continuously high, lagging by one cycle.

Source files
------------

// File: rtl/delay_ctrl.sv
// Sequencer for a RAM-based audio delay line. It clears the external address counter,
// pre-fills `offset` samples into the RAM, then reads and writes once per sample tick.
module delay_ctrl #(
    parameter int A_WIDTH = 9,
    parameter int D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [A_WIDTH-1:0] offset_in,
    input  logic               sample_tick,
    output logic               ctr_rst,
    output logic               en,
    output logic [D_WIDTH-1:0] incr,
    output logic               wr,
    output logic               rd,
    output logic [A_WIDTH-1:0] offset,
    output logic               dout_valid,
    output logic               busy,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FILL = 2'd2,
        RUN  = 2'd3
    } state_t;

    state_t             cur;
    logic [A_WIDTH-1:0] fill_cnt;
    logic               tick_ok;

    // A stop in the same cycle as a tick wins: the RAM is not touched on the way out.
    assign tick_ok = sample_tick && !stop;

    assign state = cur;
    assign busy  = (cur != IDLE);
    assign incr  = D_WIDTH'(1);

    always_comb begin
        ctr_rst = 1'b0;
        en      = 1'b0;
        wr      = 1'b0;
        rd      = 1'b0;
        case (cur)
            LOAD: ctr_rst = 1'b1;
            FILL: begin
                en = tick_ok;
                wr = tick_ok;
            end
            RUN: begin
                en = tick_ok;
                wr = tick_ok;
                rd = tick_ok;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur        <= IDLE;
            offset     <= '0;
            fill_cnt   <= '0;
            dout_valid <= 1'b0;
        end else begin
            // RAM dout is valid one cycle after a read strobe.
            dout_valid <= rd;
            case (cur)
                IDLE: begin
                    if (start) begin
                        cur      <= LOAD;
                        offset   <= offset_in;
                        fill_cnt <= offset_in;
                    end
                end
                LOAD: begin
                    if (stop)
                        cur <= IDLE;
                    else if (fill_cnt != '0)
                        cur <= FILL;
                    else
                        cur <= RUN;
                end
                FILL: begin
                    if (stop) begin
                        cur <= IDLE;
                    end else if (sample_tick) begin
                        fill_cnt <= fill_cnt - 1'b1;
                        if (fill_cnt == A_WIDTH'(1))
                            cur <= RUN;
                    end
                end
                RUN: begin
                    if (stop)
                        cur <= IDLE;
                end
                default: cur <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_delay_ctrl.sv
// Bench for delay_ctrl: a directed vector table for the named scenarios, then random
// traffic checked against a session-level model (count of samples written versus delay).
module tb_delay_ctrl;

    localparam int A_WIDTH = 9;
    localparam int D_WIDTH = 8;

    logic               clk;
    logic               rst;
    logic               start;
    logic               stop;
    logic [A_WIDTH-1:0] offset_in;
    logic               sample_tick;
    logic               ctr_rst;
    logic               en;
    logic [D_WIDTH-1:0] incr;
    logic               wr;
    logic               rd;
    logic [A_WIDTH-1:0] offset;
    logic               dout_valid;
    logic               busy;
    logic [1:0]         state;

    int n_checks;
    int n_fail;

    delay_ctrl #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .offset_in(offset_in),
        .sample_tick(sample_tick), .ctr_rst(ctr_rst), .en(en), .incr(incr), .wr(wr),
        .rd(rd), .offset(offset), .dout_valid(dout_valid), .busy(busy), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic [1:0] e_state, input logic e_ctr,
                             input logic e_en, input logic e_wr, input logic e_rd,
                             input logic e_dv, input logic [A_WIDTH-1:0] e_off);
        check("state", idx, 32'(state), 32'(e_state));
        check("busy", idx, 32'(busy), 32'(e_state != 2'd0));
        check("ctr_rst", idx, 32'(ctr_rst), 32'(e_ctr));
        check("en", idx, 32'(en), 32'(e_en));
        check("wr", idx, 32'(wr), 32'(e_wr));
        check("rd", idx, 32'(rd), 32'(e_rd));
        check("dout_valid", idx, 32'(dout_valid), 32'(e_dv));
        check("offset", idx, 32'(offset), 32'(e_off));
        check("incr", idx, 32'(incr), 32'd1);
    endtask

    typedef struct {
        logic               rst;
        logic               start;
        logic               stop;
        logic               tick;
        logic [A_WIDTH-1:0] off_in;
        logic [1:0]         e_state;
        logic               e_ctr;
        logic               e_en;
        logic               e_wr;
        logic               e_rd;
        logic               e_dv;
        logic [A_WIDTH-1:0] e_off;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic s, input logic p, input logic t,
                                input int oi, input int st, input logic c, input logic e,
                                input logic w, input logic d, input logic v, input int o);
        vec_t x;
        x.rst = r; x.start = s; x.stop = p; x.tick = t; x.off_in = A_WIDTH'(oi);
        x.e_state = 2'(st); x.e_ctr = c; x.e_en = e; x.e_wr = w; x.e_rd = d;
        x.e_dv = v; x.e_off = A_WIDTH'(o);
        return x;
    endfunction

    // Behavioural model: a session is active or not, has a load cycle, and has written
    // some number of samples; reads begin once that number reaches the delay.
    logic               m_active;
    logic               m_load;
    int                 m_writes;
    logic [A_WIDTH-1:0] m_offset;
    logic               m_dv;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; start = 1'b0; stop = 1'b0; sample_tick = 1'b0; offset_in = '0;

        //             rst st  sp  tk  oin  state ctr en wr rd dv off
        vecs.push_back(mk(1, 0, 0, 1, 0,   0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 3,   0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0,   1,  1, 0, 0, 0, 0, 3));
        vecs.push_back(mk(0, 0, 0, 1, 0,   2,  0, 1, 1, 0, 0, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0,   2,  0, 0, 0, 0, 0, 3));
        vecs.push_back(mk(0, 0, 0, 1, 0,   2,  0, 1, 1, 0, 0, 3));
        vecs.push_back(mk(0, 1, 0, 1, 7,   2,  0, 1, 1, 0, 0, 3));
        vecs.push_back(mk(0, 0, 0, 1, 0,   3,  0, 1, 1, 1, 0, 3));
        vecs.push_back(mk(0, 1, 0, 0, 9,   3,  0, 0, 0, 0, 1, 3));
        vecs.push_back(mk(0, 0, 1, 1, 0,   3,  0, 0, 0, 0, 0, 3));
        vecs.push_back(mk(0, 0, 0, 1, 0,   0,  0, 0, 0, 0, 0, 3));
        vecs.push_back(mk(0, 1, 0, 0, 0,   0,  0, 0, 0, 0, 0, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0,   1,  1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0,   3,  0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0,   3,  0, 1, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0,   3,  0, 1, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   3,  0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,   3,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 2,   0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   1,  1, 0, 0, 0, 0, 2));
        vecs.push_back(mk(1, 0, 0, 1, 0,   0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 5,   0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0,   1,  1, 0, 0, 0, 0, 5));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 0, 0, 1, 0, 2, 0, 1, 1, 0, 0, 5));
        vecs.push_back(mk(0, 0, 0, 1, 0,   3,  0, 1, 1, 1, 0, 5));
        vecs.push_back(mk(0, 0, 0, 0, 0,   3,  0, 0, 0, 0, 1, 5));
        vecs.push_back(mk(0, 0, 0, 0, 0,   3,  0, 0, 0, 0, 0, 5));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; start = vecs[i].start; stop = vecs[i].stop;
            sample_tick = vecs[i].tick; offset_in = vecs[i].off_in;
            #1;
            check_all(i, vecs[i].e_state, vecs[i].e_ctr, vecs[i].e_en, vecs[i].e_wr,
                      vecs[i].e_rd, vecs[i].e_dv, vecs[i].e_off);
        end

        // Random traffic against the model; the first cycle is a reset to align both.
        m_active = 1'b0; m_load = 1'b0; m_writes = 0; m_offset = '0; m_dv = 1'b0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            logic       act;
            logic       e_rd;
            logic [1:0] e_st;
            @(negedge clk);
            rst         = (cyc == 0) || ($urandom_range(0, 499) == 0);
            start       = ($urandom_range(0, 9) == 0);
            stop        = ($urandom_range(0, 149) == 0);
            sample_tick = ($urandom_range(0, 2) != 0);
            offset_in   = ($urandom_range(0, 24) == 0) ? A_WIDTH'(2 ** A_WIDTH - 1)
                                                       : A_WIDTH'($urandom_range(0, 12));
            #1;
            if (rst) begin
                m_active = 1'b0; m_load = 1'b0; m_writes = 0; m_offset = '0; m_dv = 1'b0;
                check_all(100000 + cyc, 2'd0, 0, 0, 0, 0, 0, '0);
            end else begin
                act  = m_active && !m_load && sample_tick && !stop;
                e_rd = act && (m_writes >= int'(m_offset));
                e_st = !m_active ? 2'd0 : m_load ? 2'd1 :
                       (m_writes < int'(m_offset)) ? 2'd2 : 2'd3;
                check_all(100000 + cyc, e_st, m_active && m_load, act, act, e_rd, m_dv,
                          m_offset);
                m_dv = e_rd;
                if (!m_active) begin
                    if (start) begin
                        m_active = 1'b1; m_load = 1'b1; m_writes = 0; m_offset = offset_in;
                    end
                end else if (stop) begin
                    m_active = 1'b0;
                end else if (m_load) begin
                    m_load = 1'b0;
                end else if (act && m_writes < int'(m_offset)) begin
                    m_writes++;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
